// File: rtl/dma_pattern_pkg.sv
// Shared encodings and constants for the DMA pattern traffic engine.
package dma_pattern_pkg;

    localparam int LANE_W = 32;

    localparam logic MODE_COUNT   = 1'b0;
    localparam logic MODE_INCWORD = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } gen_state_e;

endpackage

// File: rtl/dma_pattern_word.sv
// Combinational builder of one stream word for a given sequence value and pattern mode.
module dma_pattern_word
    import dma_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic [31:0]           seq_i,
    input  logic                  mode_i,
    output logic [DATA_WIDTH-1:0] word_o
);

    localparam int LANES = DATA_WIDTH / LANE_W;

    // Fill each 32-bit lane from the sequence value according to the mode
    always_comb begin
        word_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mode_i == MODE_INCWORD) begin
                word_o[i*LANE_W +: LANE_W] = seq_i * 32'(LANES) + 32'(i);
            end else if (i == 0) begin
                word_o[i*LANE_W +: LANE_W] = seq_i;
            end else begin
                word_o[i*LANE_W +: LANE_W] = 32'h0000_0000;
            end
        end
    end

endmodule

// File: rtl/dma_pattern_engine.sv
// C2S packet generator and S2C pattern checker with packet/error statistics.
module dma_pattern_engine
    import dma_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    m_axi_lite_aclk,
    input  logic                    m_axi_lite_areset,
    input  logic                    cfg_gen_en,
    input  logic                    cfg_gen_mode,
    input  logic [LEN_WIDTH-1:0]    cfg_pkt_beats,
    input  logic                    cfg_chk_mode,
    input  logic                    cfg_stat_clr,
    input  logic                    s2c_tvalid,
    output logic                    s2c_tready,
    input  logic [DATA_WIDTH-1:0]   s2c_tdata,
    input  logic                    s2c_tlast,
    input  logic [DATA_WIDTH/8-1:0] s2c_tkeep,
    input  logic                    c2s_tready,
    output logic                    c2s_tvalid,
    output logic [DATA_WIDTH-1:0]   c2s_tdata,
    output logic                    c2s_tlast,
    output logic [DATA_WIDTH/8-1:0] c2s_tkeep,
    output logic [CNT_WIDTH-1:0]    stat_c2s_pkts,
    output logic [CNT_WIDTH-1:0]    stat_s2c_pkts,
    output logic [CNT_WIDTH-1:0]    stat_s2c_errs,
    output logic                    gen_busy
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    gen_state_e             state_q, state_d;
    logic                   mode_q, mode_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d, idx_q, idx_d, cfg_len;
    logic [31:0]            gen_seq_q, gen_seq_d, chk_seq_q, chk_seq_d;
    logic                   c2s_fire, pkt_done, tvalid_d, tlast_d;
    logic                   c2s_tvalid_q, c2s_tlast_q, gen_busy_q, s2c_tready_q;
    logic [DATA_WIDTH-1:0]  gen_word, chk_word, c2s_tdata_q, keep_mask;
    logic [KEEP_W-1:0]      c2s_tkeep_q;
    logic                   s2c_fire, mismatch;
    logic [CNT_WIDTH-1:0]   c2s_pkts_q, s2c_pkts_q, s2c_errs_q;

    assign cfg_len  = (cfg_pkt_beats == '0) ? LEN_ONE : cfg_pkt_beats;
    assign c2s_fire = c2s_tvalid_q & c2s_tready;

    // Generator next-state: packet framing, config latching and sequence advance
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        idx_d     = idx_q;
        gen_seq_d = gen_seq_q;
        pkt_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_gen_en) begin
                    state_d = ST_SEND;
                    mode_d  = cfg_gen_mode;
                    len_d   = cfg_len;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (c2s_fire) begin
                    gen_seq_d = gen_seq_q + 32'd1;
                    if (c2s_tlast_q) begin
                        pkt_done = 1'b1;
                        idx_d    = '0;
                        if (cfg_gen_en) begin
                            mode_d = cfg_gen_mode;
                            len_d  = cfg_len;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + LEN_ONE;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The output word is built from next-state values so the registered beat is current
    assign tvalid_d = (state_d == ST_SEND);
    assign tlast_d  = tvalid_d && (idx_d == (len_d - LEN_ONE));

    dma_pattern_word #(.DATA_WIDTH(DATA_WIDTH)) u_gen_word (
        .seq_i  (gen_seq_d),
        .mode_i (mode_d),
        .word_o (gen_word)
    );

    // Generator state and registered C2S outputs
    always_ff @(posedge m_axi_lite_aclk) begin
        if (m_axi_lite_areset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_COUNT;
            len_q        <= LEN_ONE;
            idx_q        <= '0;
            gen_seq_q    <= 32'd0;
            c2s_tvalid_q <= 1'b0;
            c2s_tlast_q  <= 1'b0;
            c2s_tdata_q  <= '0;
            c2s_tkeep_q  <= '1;
            gen_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            gen_seq_q    <= gen_seq_d;
            c2s_tvalid_q <= tvalid_d;
            c2s_tlast_q  <= tlast_d;
            c2s_tdata_q  <= gen_word;
            c2s_tkeep_q  <= '1;
            gen_busy_q   <= tvalid_d;
        end
    end

    dma_pattern_word #(.DATA_WIDTH(DATA_WIDTH)) u_chk_word (
        .seq_i  (chk_seq_q),
        .mode_i (cfg_chk_mode),
        .word_o (chk_word)
    );

    // Expand byte keep into a bit mask for the comparison
    always_comb begin
        keep_mask = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            keep_mask[b*8 +: 8] = {8{s2c_tkeep[b]}};
        end
    end

    assign s2c_fire = s2c_tvalid & s2c_tready_q;
    assign mismatch = |((s2c_tdata ^ chk_word) & keep_mask);

    // Checker sequence: advance on match, resync to the received lane 0 on mismatch
    always_comb begin
        chk_seq_d = chk_seq_q;
        if (s2c_fire && mismatch) begin
            chk_seq_d = s2c_tdata[31:0] + 32'd1;
        end else if (s2c_fire) begin
            chk_seq_d = chk_seq_q + 32'd1;
        end else begin
            chk_seq_d = chk_seq_q;
        end
    end

    // Checker state and statistics; a clear pulse overrides any same-cycle increment
    always_ff @(posedge m_axi_lite_aclk) begin
        if (m_axi_lite_areset) begin
            s2c_tready_q <= 1'b0;
            chk_seq_q    <= 32'd0;
            c2s_pkts_q   <= '0;
            s2c_pkts_q   <= '0;
            s2c_errs_q   <= '0;
        end else begin
            s2c_tready_q <= 1'b1;
            chk_seq_q    <= chk_seq_d;
            if (cfg_stat_clr) begin
                c2s_pkts_q <= '0;
                s2c_pkts_q <= '0;
                s2c_errs_q <= '0;
            end else begin
                if (pkt_done) begin
                    c2s_pkts_q <= c2s_pkts_q + 1'b1;
                end
                if (s2c_fire && s2c_tlast) begin
                    s2c_pkts_q <= s2c_pkts_q + 1'b1;
                end
                if (s2c_fire && mismatch && (s2c_errs_q != '1)) begin
                    s2c_errs_q <= s2c_errs_q + 1'b1;
                end
            end
        end
    end

    assign s2c_tready    = s2c_tready_q;
    assign c2s_tvalid    = c2s_tvalid_q;
    assign c2s_tdata     = c2s_tdata_q;
    assign c2s_tlast     = c2s_tlast_q;
    assign c2s_tkeep     = c2s_tkeep_q;
    assign stat_c2s_pkts = c2s_pkts_q;
    assign stat_s2c_pkts = s2c_pkts_q;
    assign stat_s2c_errs = s2c_errs_q;
    assign gen_busy      = gen_busy_q;

endmodule

// File: tb/tb_dma_pattern_engine.sv
// Scoreboard bench for dma_pattern_engine: C2S beats checked against a queue of expected beats.
module tb_dma_pattern_engine;

    localparam int DW = 256;
    localparam int LW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          areset;
    logic          cfg_gen_en, cfg_gen_mode, cfg_chk_mode, cfg_stat_clr;
    logic [LW-1:0] cfg_pkt_beats;
    logic          s2c_tvalid, s2c_tready, s2c_tlast;
    logic [DW-1:0] s2c_tdata;
    logic [31:0]   s2c_tkeep;
    logic          c2s_tready, c2s_tvalid, c2s_tlast;
    logic [DW-1:0] c2s_tdata;
    logic [31:0]   c2s_tkeep;
    logic [CW-1:0] stat_c2s_pkts, stat_s2c_pkts, stat_s2c_errs;
    logic          gen_busy;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_seq = 32'd0;

    always #5 clk = ~clk;

    dma_pattern_engine #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .m_axi_lite_aclk   (clk),
        .m_axi_lite_areset (areset),
        .cfg_gen_en        (cfg_gen_en),
        .cfg_gen_mode      (cfg_gen_mode),
        .cfg_pkt_beats     (cfg_pkt_beats),
        .cfg_chk_mode      (cfg_chk_mode),
        .cfg_stat_clr      (cfg_stat_clr),
        .s2c_tvalid        (s2c_tvalid),
        .s2c_tready        (s2c_tready),
        .s2c_tdata         (s2c_tdata),
        .s2c_tlast         (s2c_tlast),
        .s2c_tkeep         (s2c_tkeep),
        .c2s_tready        (c2s_tready),
        .c2s_tvalid        (c2s_tvalid),
        .c2s_tdata         (c2s_tdata),
        .c2s_tlast         (c2s_tlast),
        .c2s_tkeep         (c2s_tkeep),
        .stat_c2s_pkts     (stat_c2s_pkts),
        .stat_s2c_pkts     (stat_s2c_pkts),
        .stat_s2c_errs     (stat_s2c_errs),
        .gen_busy          (gen_busy)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] s, input logic m);
        logic [DW-1:0] w;
        w = '0;
        if (m) begin
            for (int i = 0; i < 8; i++) w[i*32 +: 32] = s * 32'd8 + 32'(i);
        end else begin
            w[31:0] = s;
        end
        return w;
    endfunction

    // Push expected beats, run the generator, pop and compare each accepted beat
    task automatic run_gen(input logic mode, input logic [LW-1:0] beats, input int plen,
                           input int npkts, input bit toggle);
        int          n_tot, acc, cyc;
        bit          held;
        logic [DW-1:0] held_d;
        logic        held_l;
        beat_t       e;
        n_tot = plen * npkts;
        for (int k = 0; k < n_tot; k++) begin
            e.data = pat(model_seq, mode);
            e.last = ((k % plen) == plen - 1);
            exp_q.push_back(e);
            model_seq = model_seq + 32'd1;
        end
        @(negedge clk);
        cfg_gen_mode  = mode;
        cfg_pkt_beats = beats;
        cfg_gen_en    = 1'b1;
        c2s_tready    = 1'b1;
        acc = 0; cyc = 0; held = 1'b0;
        while (acc < n_tot && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_val("tvalid_rise", 256'(c2s_tvalid), 256'(1'b1));
            if (toggle) c2s_tready = (cyc % 2) == 1;
            if (held) begin
                check_val("stall_data", c2s_tdata, held_d);
                check_val("stall_last", 256'(c2s_tlast), 256'(held_l));
            end
            held = 1'b0;
            if (c2s_tvalid && c2s_tready) begin
                e = exp_q.pop_front();
                check_val("beat_data", c2s_tdata, e.data);
                check_val("beat_last", 256'(c2s_tlast), 256'(e.last));
                check_val("beat_keep", 256'(c2s_tkeep), 256'(32'hFFFF_FFFF));
                if (acc == n_tot - 1) cfg_gen_en = 1'b0;
                acc++;
            end else if (c2s_tvalid) begin
                held   = 1'b1;
                held_d = c2s_tdata;
                held_l = c2s_tlast;
            end
        end
        check_val("gen_beats", 256'(acc), 256'(n_tot));
        if (!toggle) check_val("no_gap", 256'(cyc), 256'(n_tot));
        cfg_gen_en = 1'b0;
        c2s_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("idle_valid", 256'(c2s_tvalid), 256'(1'b0));
        check_val("idle_busy", 256'(gen_busy), 256'(1'b0));
    endtask

    task automatic s2c_beat(input logic [DW-1:0] d, input logic last, input logic [31:0] keep,
                            input logic clr);
        @(negedge clk);
        s2c_tvalid   = 1'b1;
        s2c_tdata    = d;
        s2c_tlast    = last;
        s2c_tkeep    = keep;
        cfg_stat_clr = clr;
        @(negedge clk);
        s2c_tvalid   = 1'b0;
        s2c_tlast    = 1'b0;
        cfg_stat_clr = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        cfg_stat_clr = 1'b1;
        @(negedge clk);
        cfg_stat_clr = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        int            n, cyc;
        areset = 1'b1;
        cfg_gen_en = 1'b0; cfg_gen_mode = 1'b0; cfg_chk_mode = 1'b0; cfg_stat_clr = 1'b0;
        cfg_pkt_beats = 16'd4;
        s2c_tvalid = 1'b0; s2c_tdata = '0; s2c_tlast = 1'b0; s2c_tkeep = 32'hFFFF_FFFF;
        c2s_tready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_valid", 256'(c2s_tvalid), 256'(1'b0));
        check_val("rst_last", 256'(c2s_tlast), 256'(1'b0));
        check_val("rst_data", c2s_tdata, '0);
        check_val("rst_keep", 256'(c2s_tkeep), 256'(32'hFFFF_FFFF));
        check_val("rst_s2c_ready", 256'(s2c_tready), 256'(1'b0));
        check_val("rst_stats", 256'({stat_c2s_pkts, stat_s2c_pkts, stat_s2c_errs}), 256'(12'h000));
        check_val("rst_busy", 256'(gen_busy), 256'(1'b0));
        areset = 1'b0;
        @(negedge clk);
        check_val("s2c_ready", 256'(s2c_tready), 256'(1'b1));

        run_gen(1'b0, 16'd4, 4, 2, 1'b0);
        check_val("c2s_pkts_2", 256'(stat_c2s_pkts), 256'(4'd2));
        run_gen(1'b1, 16'd4, 4, 2, 1'b1);
        check_val("c2s_pkts_4", 256'(stat_c2s_pkts), 256'(4'd4));
        run_gen(1'b0, 16'd0, 1, 3, 1'b0);
        check_val("c2s_pkts_7", 256'(stat_c2s_pkts), 256'(4'd7));

        // Checker resync: 0,1,2,7,8 in COUNT with tlast on 2 and 8
        s2c_beat(pat(32'd0, 1'b0), 1'b0, 32'hFFFF_FFFF, 1'b0);
        s2c_beat(pat(32'd1, 1'b0), 1'b0, 32'hFFFF_FFFF, 1'b0);
        s2c_beat(pat(32'd2, 1'b0), 1'b1, 32'hFFFF_FFFF, 1'b0);
        s2c_beat(pat(32'd7, 1'b0), 1'b0, 32'hFFFF_FFFF, 1'b0);
        check_val("errs_after_7", 256'(stat_s2c_errs), 256'(4'd1));
        s2c_beat(pat(32'd8, 1'b0), 1'b1, 32'hFFFF_FFFF, 1'b0);
        check_val("errs_resync", 256'(stat_s2c_errs), 256'(4'd1));
        check_val("s2c_pkts_2", 256'(stat_s2c_pkts), 256'(4'd2));

        // INCWORD with garbage in masked-off bytes, then a full-keep beat
        cfg_chk_mode = 1'b1;
        d = pat(32'd9, 1'b1);
        d[DW-1:32] = {7{32'hDEAD_BEEF}};
        s2c_beat(d, 1'b0, 32'h0000_000F, 1'b0);
        s2c_beat(pat(32'd10, 1'b1), 1'b0, 32'hFFFF_FFFF, 1'b0);
        check_val("errs_keep", 256'(stat_s2c_errs), 256'(4'd1));
        cfg_chk_mode = 1'b0;

        // Sequence wrap through resync at all-ones
        s2c_beat(pat(32'hFFFF_FFFF, 1'b0), 1'b0, 32'hFFFF_FFFF, 1'b0);
        s2c_beat(pat(32'd0, 1'b0), 1'b0, 32'hFFFF_FFFF, 1'b0);
        s2c_beat(pat(32'd1, 1'b0), 1'b0, 32'hFFFF_FFFF, 1'b0);
        check_val("errs_wrap", 256'(stat_s2c_errs), 256'(4'd2));

        pulse_clr();
        check_val("clr_stats", 256'({stat_c2s_pkts, stat_s2c_pkts, stat_s2c_errs}), 256'(12'h000));

        // Saturation: repeated lane0=100 always mismatches after the first resync
        for (int k = 0; k < 15; k++) s2c_beat(pat(32'd100, 1'b0), 1'b0, 32'hFFFF_FFFF, 1'b0);
        check_val("errs_15", 256'(stat_s2c_errs), 256'(4'hF));
        s2c_beat(pat(32'd100, 1'b0), 1'b0, 32'hFFFF_FFFF, 1'b0);
        s2c_beat(pat(32'd100, 1'b0), 1'b1, 32'hFFFF_FFFF, 1'b0);
        check_val("errs_sat", 256'(stat_s2c_errs), 256'(4'hF));
        check_val("s2c_pkts_1", 256'(stat_s2c_pkts), 256'(4'd1));
        s2c_beat(pat(32'd101, 1'b0), 1'b1, 32'hFFFF_FFFF, 1'b1);
        check_val("clr_vs_tlast", 256'({stat_c2s_pkts, stat_s2c_pkts, stat_s2c_errs}), 256'(12'h000));

        // Reset in the middle of a 4-beat packet
        run_gen(1'b0, 16'd2, 2, 1, 1'b0);
        @(negedge clk);
        cfg_gen_mode = 1'b0; cfg_pkt_beats = 16'd4; cfg_gen_en = 1'b1; c2s_tready = 1'b1;
        n = 0; cyc = 0;
        while (n < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (c2s_tvalid && c2s_tready) begin
                check_val("pre_rst_data", c2s_tdata, pat(model_seq, 1'b0));
                model_seq = model_seq + 32'd1;
                n++;
            end
        end
        check_val("pre_rst_beats", 256'(n), 256'(2));
        @(negedge clk);
        areset = 1'b1;
        cfg_gen_en = 1'b0;
        @(negedge clk);
        check_val("mid_rst_valid", 256'(c2s_tvalid), 256'(1'b0));
        check_val("mid_rst_last", 256'(c2s_tlast), 256'(1'b0));
        check_val("mid_rst_stats", 256'({stat_c2s_pkts, stat_s2c_pkts, stat_s2c_errs}), 256'(12'h000));
        check_val("mid_rst_busy", 256'(gen_busy), 256'(1'b0));
        areset = 1'b0;
        model_seq = 32'd0;
        exp_q.delete();
        run_gen(1'b0, 16'd2, 2, 1, 1'b0);
        check_val("post_rst_pkts", 256'(stat_c2s_pkts), 256'(4'd1));
        check_val("queue_empty", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_pattern_engine.md
# dma_pattern_engine

Parametrised traffic engine on the DMA streaming interface, replacing the fixed free-running counter source and always-ready sink. On C2S it generates framed packets of configurable beat length in one of two data patterns. On S2C it checks incoming data against the same pattern and counts packets and errors. It sits between the DMA engine's AXI-Stream ports and the register block, which drives the `cfg_*` inputs and reads the `stat_*` outputs.

## Interface
- `DATA_WIDTH`, 256: stream data width in bits; multiple of 32.
- `LEN_WIDTH`, 16: width of the packet-length field, in beats.
- `CNT_WIDTH`, 32: width of the statistics counters.
- `m_axi_lite_aclk` in 1: single clock; all logic on its rising edge.
- `m_axi_lite_areset` in 1: synchronous, active-high reset.
- `cfg_gen_en` in 1: enable C2S generation.
- `cfg_gen_mode` in 1: C2S pattern; 0 = COUNT, 1 = INCWORD.
- `cfg_pkt_beats` in LEN_WIDTH: C2S packet length in beats; 0 is treated as 1.
- `cfg_chk_mode` in 1: S2C expected pattern; same encoding as `cfg_gen_mode`.
- `cfg_stat_clr` in 1: single-cycle pulse that clears all `stat_*` counters.
- `s2c_tvalid` in 1, `s2c_tready` out 1, `s2c_tdata` in DATA_WIDTH, `s2c_tlast` in 1, `s2c_tkeep` in DATA_WIDTH/8: S2C input stream.
- `c2s_tready` in 1, `c2s_tvalid` out 1, `c2s_tdata` out DATA_WIDTH, `c2s_tlast` out 1, `c2s_tkeep` out DATA_WIDTH/8: C2S output stream.
- `stat_c2s_pkts` out CNT_WIDTH: C2S packets sent; wraps.
- `stat_s2c_pkts` out CNT_WIDTH: S2C packets received; wraps.
- `stat_s2c_errs` out CNT_WIDTH: S2C beats that mismatched; saturates at all-ones.
- `gen_busy` out 1: high while the generator is not in IDLE.

## Operation
- Lanes: LANES = DATA_WIDTH/32; lane i is bits [32i+31:32i].
- Pattern for sequence value `seq` (32 bits):
  - COUNT: lane 0 = `seq`; all other lanes = 0.
  - INCWORD: lane i = `seq*LANES + i`, computed mod 2^32.
- Generator FSM has two states, IDLE and SEND.
  - IDLE→SEND when `cfg_gen_en`=1. On this transition, latch `cfg_gen_mode` and `cfg_pkt_beats` (0 latched as 1) and clear the beat index.
  - In SEND, `c2s_tvalid`=1. `c2s_tlast`=1 when beat index = latched length−1. `c2s_tkeep` is all ones.
  - On each accepted beat (`tvalid && tready`): increment `gen_seq` (32-bit, wraps at 2^32→0) and increment the beat index.
  - On an accepted last beat: increment `stat_c2s_pkts`. Then either re-latch config and stay in SEND if `cfg_gen_en`=1 (back-to-back, no gap), or go to IDLE.
  - Deasserting `cfg_gen_en` mid-packet does not truncate: the packet completes. Config changes mid-packet are ignored until the next packet.
- Checker:
  - `s2c_tready` is 1 whenever not in reset.
  - Each accepted beat is compared to pattern(`chk_seq`, `cfg_chk_mode`), byte-masked by `s2c_tkeep`.
  - Match: `chk_seq` ← `chk_seq`+1.
  - Mismatch: `stat_s2c_errs` increments (saturating), and `chk_seq` ← received lane 0 + 1 (resync).
  - `s2c_tlast` on an accepted beat increments `stat_s2c_pkts`.
- `cfg_stat_clr` clears all three counters. If it coincides with an increment event, the clear wins and the counter reads 0. `gen_seq` and `chk_seq` are not affected.

## Timing
- Reset values:
  - `c2s_tvalid`=0, `c2s_tlast`=0, `c2s_tdata`=0, `c2s_tkeep`=all ones.
  - `s2c_tready`=0 during reset.
  - All `stat_*`=0, `gen_busy`=0, `gen_seq`=0, `chk_seq`=0, FSM=IDLE.
- All outputs are registered.
- `c2s_tvalid` rises on the cycle after the first edge that samples `cfg_gen_en`=1 in IDLE.
- While `c2s_tvalid`=1 and `c2s_tready`=0, `c2s_tdata`, `c2s_tlast` and `c2s_tkeep` hold stable.
- With `c2s_tready` tied high, throughput is one beat per cycle, including across packet boundaries.
- Statistics update one cycle after the causing beat is accepted.
- Reset asserted mid-packet aborts the packet immediately. There is no trailing `tlast`.

## Structure
- Package `dma_pattern_pkg`:
  - mode encodings `MODE_COUNT`=0, `MODE_INCWORD`=1;
  - FSM state type (IDLE, SEND);
  - the lane-width constant of 32.
- Sub-module `dma_pattern_word`: combinational builder of pattern(`seq`, `mode`) at DATA_WIDTH. One instance serves the generator and one the checker.

## Test plan
- Generation: `cfg_pkt_beats`=4, COUNT, `c2s_tready`=1, `cfg_gen_en` held for 8 cycles → lane 0 = 0,1,2,…; `tlast` on seq 3 and 7; `stat_c2s_pkts`=2 when en drops after a boundary.
- Backpressure: INCWORD, LANES=8, `c2s_tready` toggling 1010… → beat n lane i = 8n+i; no beat skipped or duplicated; data stable while stalled.
- Wrap and zero length: `gen_seq` forced near 0xFFFFFFFF, `cfg_pkt_beats`=0 → every beat has `tlast`=1; lane 0 goes 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
- Checker resync: feed COUNT beats 0,1,2,7,8 → `stat_s2c_errs`=1, no further errors after 7; `tlast` on beats 2 and 8 → `stat_s2c_pkts`=2.
- Clear and saturation: `stat_s2c_errs` preset to all-ones plus one mismatch → stays all-ones; `cfg_stat_clr` in the same cycle as a `tlast` → all counters read 0.
- Reset mid-packet: assert `m_axi_lite_areset` at beat 2 of 4 → next cycle `c2s_tvalid`=0 and all stats 0; after release, generation restarts at seq 0.
